// File: rtl/cpu_io_bridge.sv
// cpu_io_bridge: memory-mapped TX byte FIFO plus single-byte RX interrupt latch between execute and decode
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   addr, w_req, w_data execute store request; a store to TX_ADDR enqueues w_data[7:0]
//   w_busy              TX FIFO full
//   tx_valid, tx_data   FIFO head towards the byte-stream peripheral
//   tx_ready            peripheral accepts the head byte this cycle
//   rx_valid, rx_data   incoming byte strobe
//   intr_en             interrupt enable from execute
//   irr, r_data         pending interrupt and latched input word for decode
//   ack                 execute acknowledges the pending interrupt
//
// Build option: CPU_IO_OVERRUN_EN adds a sticky overrun flag in r_data[8].
module cpu_io_bridge #(
    parameter int          DEPTH   = 4,
    parameter logic [31:0] TX_ADDR = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        w_req,
    input  logic [31:0] w_data,
    output logic        w_busy,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        intr_en,
    output logic        irr,
    output logic [31:0] r_data,
    input  logic        ack
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    logic          unused_bits;

    assign unused_bits = ^w_data[31:8];
    assign w_busy      = count == FULL;
    assign tx_valid    = count != '0;
    assign tx_data     = tx_valid ? mem[rd_ptr] : 8'h00;
    assign push        = w_req && addr == TX_ADDR && !w_busy;
    assign pop         = tx_valid && tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
        end
    end

    // Storage needs no reset: tx_data is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= w_data[7:0];
    end

    typedef enum logic {IDLE, PEND} rx_state_t;
    rx_state_t  state, next_state;
    logic [7:0] r_byte;
    logic       load;

    // In PEND a byte is only taken alongside an ack, so the ack is honoured first.
    assign load = rx_valid && intr_en && (state == IDLE || ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= next_state;
    end

    always_comb begin
        next_state = load ? PEND : (state == PEND && ack) ? IDLE : state;
    end

    always_comb begin
        irr = state == PEND;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_byte <= '0;
        else if (load) r_byte <= rx_data;
    end

`ifdef CPU_IO_OVERRUN_EN
    logic ovf;

    // Any ack clears the flag, which also makes a same-cycle reload start clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf <= 1'b0;
        else if (state == PEND) ovf <= ack ? 1'b0 : (rx_valid || ovf);
    end

    assign r_data = {23'b0, ovf, r_byte};
`else
    assign r_data = {24'b0, r_byte};
`endif
endmodule

// File: tb/tb_cpu_io_bridge.sv
// tb_cpu_io_bridge: vector table, directed corner sequences and randomized model comparison for cpu_io_bridge
module tb_cpu_io_bridge;
    localparam int          DEPTH = 4;
    localparam logic [31:0] TXA   = 32'hFFFF_FF00;
`ifdef CPU_IO_OVERRUN_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] addr = '0, w_data = '0;
    logic        w_req = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0, intr_en = 1'b0, ack = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        w_busy, tx_valid, irr;
    logic [7:0]  tx_data;
    logic [31:0] r_data;

    int passed = 0, total = 0;

    cpu_io_bridge #(.DEPTH(DEPTH), .TX_ADDR(TXA)) dut (
        .clk(clk), .rst(rst), .addr(addr), .w_req(w_req), .w_data(w_data),
        .w_busy(w_busy), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .intr_en(intr_en), .irr(irr),
        .r_data(r_data), .ack(ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       at_tx;
        logic [7:0] wd;
        logic       rdy;
        logic       rv;
        logic [7:0] rd;
        logic       ie;
        logic       ak;
        logic       ev;
        logic [7:0] ed;
        logic       eb;
        logic       ei;
        logic [31:0] er;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_req = 0; addr = 0; w_data = 0; tx_ready = 0; rx_valid = 0; rx_data = 0; ack = 0;
    endtask

    task automatic store(input logic [7:0] b);
        w_req = 1; addr = TXA; w_data = {24'hC0FFEE, b};
        step();
        w_req = 0;
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [7:0] ed, input logic eb,
                           input logic ei, input logic [31:0] er);
        chk({tag, " tx_valid"}, tx_valid, ev);
        chk({tag, " tx_data"}, tx_data, ed);
        chk({tag, " w_busy"}, w_busy, eb);
        chk({tag, " irr"}, irr, ei);
        chk({tag, " r_data"}, r_data, er);
    endtask

    initial begin
        logic [7:0] q[$];
        logic       pend, ov, busy, psh, pp;
        logic [7:0] rb;
        logic [31:0] er;

        tbl[0] = '{1, 1, 8'h41, 1, 0, 8'h00, 0, 0, 1, 8'h41, 0, 0, 32'h0};
        tbl[1] = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 32'h0};
        tbl[2] = '{1, 0, 8'h99, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 32'h0};
        tbl[3] = '{0, 0, 8'h00, 0, 1, 8'h5A, 1, 0, 0, 8'h00, 0, 1, 32'h5A};
        tbl[4] = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 32'h5A};
        tbl[5] = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 32'h5A};
        tbl[6] = '{0, 0, 8'h00, 0, 1, 8'h33, 0, 0, 0, 8'h00, 0, 0, 32'h5A};
        tbl[7] = '{1, 1, 8'h22, 0, 1, 8'h10, 1, 0, 1, 8'h22, 0, 1, 32'h10};
        tbl[8] = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 32'h10};

        step();
        step();
        chk_all("reset", 0, 8'h00, 0, 0, 32'h0);
        rst = 0;

        for (int i = 0; i < 9; i++) begin
            w_req = tbl[i].wr; addr = tbl[i].at_tx ? TXA : 32'h0000_1000;
            w_data = {24'hC0FFEE, tbl[i].wd}; tx_ready = tbl[i].rdy;
            rx_valid = tbl[i].rv; rx_data = tbl[i].rd; intr_en = tbl[i].ie; ack = tbl[i].ak;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eb, tbl[i].ei, tbl[i].er);
        end
        idle(); ack = 1; step(); idle();
        chk("clear irr", irr, 0);

        for (int b = 1; b <= 4; b++) store(8'(b));
        chk("full busy", w_busy, 1);
        store(8'h05);
        chk("discard busy", w_busy, 1);
        chk("discard head", tx_data, 8'h01);
        tx_ready = 1;
        for (int b = 1; b <= 4; b++) begin
            chk($sformatf("drain%0d valid", b), tx_valid, 1);
            chk($sformatf("drain%0d data", b), tx_data, 8'(b));
            step();
        end
        chk("drain empty", tx_valid, 0);
        tx_ready = 0;

        store(8'hB1); store(8'hB2); store(8'hB3);
        chk("cnt3 busy", w_busy, 0);
        chk("cnt3 head", tx_data, 8'hB1);
        tx_ready = 1;
        store(8'hAA);
        tx_ready = 0;
        chk("pushpop busy", w_busy, 0);
        chk("pushpop head", tx_data, 8'hB2);
        store(8'hCC);
        chk("pushpop count kept", w_busy, 1);
        tx_ready = 1;
        foreach (q[i]) q.delete();
        q = '{8'hB2, 8'hB3, 8'hAA, 8'hCC};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap out%0d", i), tx_data, q[i]);
            step();
        end
        chk("wrap empty", tx_valid, 0);
        idle();

        intr_en = 1; rx_valid = 1; rx_data = 8'h5A; step(); idle();
        chk("ovr pend irr", irr, 1);
        rx_valid = 1; rx_data = 8'h77; step(); idle();
        chk("ovr irr", irr, 1);
        chk("ovr r_data", r_data, OVR ? 32'h15A : 32'h5A);
        ack = 1; step(); idle();
        chk("ovr ack irr", irr, 0);
        chk("ovr ack r_data", r_data, 32'h5A);

        rx_valid = 1; rx_data = 8'h5A; step(); idle();
        ack = 1; rx_valid = 1; rx_data = 8'h10; step(); idle();
        chk("ack+rx irr", irr, 1);
        chk("ack+rx r_data", r_data, 32'h10);
        store(8'h61); store(8'h62); store(8'h63); store(8'h64);
        chk_all("pre-rst", 1, 8'h61, 1, 1, 32'h10);
        tx_ready = 1; rx_valid = 1; rx_data = 8'hEE;
        #3 rst = 1;
        #1 chk_all("async rst", 0, 8'h00, 0, 0, 32'h0);
        step();
        idle(); rst = 0;

        q.delete(); pend = 0; ov = 0; rb = 0;
        for (int i = 0; i < 3000; i++) begin
            w_req = $urandom_range(0, 1);
            addr = ($urandom_range(0, 3) != 0) ? TXA : $urandom;
            w_data = $urandom;
            tx_ready = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rx_valid = $urandom_range(0, 2) == 0;
            rx_data = 8'($urandom);
            intr_en = $urandom_range(0, 3) != 0;
            ack = $urandom_range(0, 3) == 0;
            busy = q.size() == DEPTH;
            psh = w_req && addr == TXA && !busy;
            pp = q.size() != 0 && tx_ready;
            if (pp) void'(q.pop_front());
            if (psh) q.push_back(w_data[7:0]);
            if (!pend) begin
                if (rx_valid && intr_en) begin pend = 1; rb = rx_data; end
            end else if (ack) begin
                ov = 0;
                if (rx_valid && intr_en) rb = rx_data;
                else pend = 0;
            end else if (rx_valid && OVR) ov = 1;
            step();
            er = {23'b0, ov, rb};
            chk_all($sformatf("rand%0d", i), q.size() != 0, q.size() != 0 ? q[0] : 8'h00,
                    q.size() == DEPTH, pend, er);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
